// File: rtl/input_loader.sv
// rtl/input_loader.sv - gathers N stream words into a vector and launches it to the controller
// Optional LOADER_PREFETCH_EN: second bank so the next vector fills while the current one computes.
module input_loader #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           done,
  output logic           start,
  output logic [N*W-1:0] vec_out,
  output logic           busy,
  output logic [CW-1:0]  vec_cnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef LOADER_PREFETCH_EN
  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_FULL} state_t;
`else
  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic                r_live;
  logic                r_done_q;
  logic                r_start;
  logic                r_busy;
  logic [CW-1:0]       r_vec_cnt;
  logic [N-1:0][W-1:0] r_bank, w_bank_nxt;
  logic                w_accept;
  logic                w_last;
  logic                w_done_rise;

  // r_live keeps in_ready low until the first edge after reset release.
`ifdef LOADER_PREFETCH_EN
  logic [N-1:0][W-1:0] r_active;
  assign in_ready = r_live & ((r_state == S_FILL) | (r_state == S_WAIT));
  assign vec_out  = r_active;
`else
  assign in_ready = r_live & (r_state == S_FILL);
  assign vec_out  = r_bank;
`endif

  assign w_accept    = in_valid & in_ready;
  assign w_last      = w_accept & (r_idx == IW'(N - 1));
  assign w_done_rise = done & ~r_done_q;
  assign start       = r_start;
  assign busy        = r_busy;
  assign vec_cnt     = r_vec_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bank_nxt  = r_bank;
    if (w_accept) begin
      w_bank_nxt[r_idx] = in_data;
      w_idx_nxt         = w_last ? '0 : r_idx + IW'(1);
    end
    case (r_state)
      S_FILL:   if (w_last) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
`ifdef LOADER_PREFETCH_EN
      S_WAIT: begin
        if (w_done_rise)  w_state_nxt = w_last ? S_LAUNCH : S_FILL;
        else if (w_last)  w_state_nxt = S_FULL;
      end
      S_FULL:   if (w_done_rise) w_state_nxt = S_LAUNCH;
`else
      S_WAIT:   if (w_done_rise) w_state_nxt = S_FILL;
`endif
      default:  w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FILL;
      r_idx     <= '0;
      r_live    <= 1'b0;
      r_done_q  <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_vec_cnt <= '0;
      r_bank    <= '0;
`ifdef LOADER_PREFETCH_EN
      r_active  <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_live    <= 1'b1;
      r_done_q  <= done;
      r_bank    <= w_bank_nxt;
      r_start   <= (w_state_nxt == S_LAUNCH);
      r_busy    <= (w_state_nxt != S_FILL);
      if (w_state_nxt == S_LAUNCH) begin
        r_vec_cnt <= r_vec_cnt + CW'(1);
`ifdef LOADER_PREFETCH_EN
        r_active  <= w_bank_nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - randomized self-checking bench for input_loader
// Covers prefetch behaviour when LOADER_PREFETCH_EN is defined.
module tb_input_loader;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           done = 1'b0;
  logic           start;
  logic [N*W-1:0] vec_out;
  logic           busy;
  logic [CW-1:0]  vec_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int launches = 0;

  input_loader #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .done(done), .start(start), .vec_out(vec_out), .busy(busy), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_vec(input int maxw);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(0, maxw));
    return v;
  endfunction

  // Streams v word by word; gap < 0 picks a random idle gap of 0..2 per word.
  task automatic send_vec(input logic [N*W-1:0] v, input int gap, input bit expect_launch);
    int g;
    int t;
    for (int i = 0; i < N; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      repeat (g) step();
      in_valid = 1'b1;
      in_data  = v[i*W +: W];
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin step(); t++; end
      if (t >= 50) begin
        n_cmp++; n_err++;
        $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
      end
      n_cmp++;
      if (start !== 1'b0) begin n_err++; $display("FAIL start_early: start=%b required 0", start); end
      step();
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
    if (expect_launch) begin
      launches++;
      n_cmp++;
      if (start !== 1'b1) begin n_err++; $display("FAIL start_pulse: start=%b required 1", start); end
      n_cmp++;
      if (vec_out !== v) begin n_err++; $display("FAIL vec_out: got %h required %h", vec_out, v); end
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL busy_launch: busy=%b required 1", busy); end
      n_cmp++;
      if (vec_cnt !== CW'(launches)) begin
        n_err++; $display("FAIL vec_cnt: got %0d required %0d", vec_cnt, CW'(launches));
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_launch: in_ready=%b required 0", in_ready); end
    end
  endtask

  task automatic do_done();
    done = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy: busy=%b required 0", busy); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL done_ready: in_ready=%b required 1", in_ready); end
    done = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    launches = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if ({start, busy, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: start,busy,in_ready=%b required 000", {start, busy, in_ready});
    end
    n_cmp++;
    if (vec_out !== '0 || vec_cnt !== '0) begin
      n_err++; $display("FAIL reset_data: vec_out=%h vec_cnt=%0d required 0/0", vec_out, vec_cnt);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_release: in_ready=%b required 0", in_ready); end
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_first_edge: in_ready=%b required 1", in_ready); end
    launches = 0;
  endtask

  task automatic test_basic();
    send_vec(32'h44332211, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({start, busy, in_ready} !== 3'b010) begin
        n_err++; $display("FAIL basic_wait: start,busy,in_ready=%b required 010", {start, busy, in_ready});
      end
    end
    do_done();
  endtask

  task automatic test_stale_done();
    int sb;
    send_vec(rand_vec(255), 3, 1'b1);
    step();
    done = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL stale_first_done: busy=%b required 0", busy); end
    repeat (10) step();
    sb = start_cnt;
    send_vec(32'hA3A2A1A0, 1, 1'b1);
    repeat (5) step();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL stale_retrigger: busy=%b required 1", busy); end
    n_cmp++;
    if (start_cnt !== sb + 1) begin n_err++; $display("FAIL stale_starts: got %0d required %0d", start_cnt - sb, 1); end
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL stale_new_rise: busy=%b required 0", busy); end
    done = 1'b0;
    step();
    send_vec(rand_vec(255), -1, 1'b1);
    done = 1'b1;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL launch_done_ignored: busy=%b required 1", busy); end
    done = 1'b0;
    step();
    do_done();
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({start, busy, in_ready} !== 3'b000 || vec_out !== '0 || vec_cnt !== '0) begin
      n_err++; $display("FAIL async_reset_fill: flags=%b vec_out=%h vec_cnt=%0d required zeros",
                        {start, busy, in_ready}, vec_out, vec_cnt);
    end
    step();
    rst = 1'b1;
    step();
    launches = 0;
    send_vec(rand_vec(255), 0, 1'b1);
    step();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({start, busy, in_ready} !== 3'b000 || vec_out !== '0 || vec_cnt !== '0) begin
      n_err++; $display("FAIL async_reset_wait: flags=%b vec_out=%h vec_cnt=%0d required zeros",
                        {start, busy, in_ready}, vec_out, vec_cnt);
    end
    step();
    rst = 1'b1;
    step();
    launches = 0;
    send_vec(rand_vec(255), -1, 1'b1);
    step();
    do_done();
  endtask

  task automatic test_wrap();
    int sb;
    apply_reset();
    sb = start_cnt;
    for (int k = 0; k < 257; k++) begin
      send_vec(rand_vec(255), (k % 8 == 0) ? -1 : 0, 1'b1);
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    step();
    n_cmp++;
    if (vec_cnt !== CW'(1)) begin n_err++; $display("FAIL wrap_cnt: got %0d required 1", vec_cnt); end
    n_cmp++;
    if (start_cnt - sb !== 257) begin n_err++; $display("FAIL wrap_starts: got %0d required 257", start_cnt - sb); end
  endtask

`ifndef LOADER_PREFETCH_EN
  task automatic test_ignored();
    logic [N*W-1:0] v;
    v = rand_vec(254);
    send_vec(v, 0, 1'b1);
    step();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (in_ready !== 1'b0 || vec_out !== v) begin
        n_err++; $display("FAIL ignored_junk: in_ready=%b vec_out=%h required 0/%h", in_ready, vec_out, v);
      end
    end
    in_valid = 1'b0;
    do_done();
    send_vec(rand_vec(254), 0, 1'b1);
    step();
    do_done();
  endtask
`else
  task automatic test_prefetch();
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    a = rand_vec(255);
    b = rand_vec(255);
    send_vec(a, 0, 1'b1);
    step();
    send_vec(b, -1, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL pf_full_ready: in_ready=%b required 0", in_ready); end
    repeat (3) step();
    n_cmp++;
    if (vec_out !== a || busy !== 1'b1) begin
      n_err++; $display("FAIL pf_hold: vec_out=%h busy=%b required %h/1", vec_out, busy, a);
    end
    done = 1'b1;
    step();
    launches++;
    n_cmp++;
    if (start !== 1'b1 || vec_out !== b) begin
      n_err++; $display("FAIL pf_turnaround: start=%b vec_out=%h required 1/%h", start, vec_out, b);
    end
    n_cmp++;
    if (vec_cnt !== CW'(launches)) begin
      n_err++; $display("FAIL pf_cnt: got %0d required %0d", vec_cnt, CW'(launches));
    end
    done = 1'b0;
    step();
    do_done();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stale_done();
    test_mid_reset();
`ifndef LOADER_PREFETCH_EN
    test_ignored();
`else
    test_prefetch();
`endif
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
